mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request front-end for the single-port synchronous memory (addr/wr_en/rd_en/wdata in, registered rdata out, 1-cycle read latency). It accepts read/write requests from a host over a valid/ready handshake, buffers them in an in-order FIFO, and drives the memory control pins. It captures read data into a backpressured response register. An optional post-reset sweep writes every memory location with a known value.

## Interface
- ADDR_WIDTH, 2, memory address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, data width
- FIFO_DEPTH, 4, request FIFO entries; power of 2, ≥2
- INIT_VALUE, {DATA_WIDTH{1'b1}}, value written by the init sweep
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_WIDTH  read data
- busy  out  1  init sweep in progress
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_wr_en  out  1  to memory wr_en
- mem_rd_en  out  1  to memory rd_en
- mem_wdata  out  DATA_WIDTH  to memory wdata
- mem_rdata  in  DATA_WIDTH  from memory rdata, valid the cycle after mem_rd_en

## Operation
- States: INIT (sweep), RUN. Reset enters INIT if the macro is defined, otherwise RUN.
- INIT:
  - sweep counter runs 0..2**ADDR_WIDTH-1, one address per cycle.
  - Drives mem_wr_en=1, mem_addr=counter, mem_wdata=INIT_VALUE.
  - busy=1, req_ready=0.
  - Transitions to RUN after the cycle that writes the last address.
- req_ready = (state==RUN) && (count < FIFO_DEPTH). A push is refused when full, even if a pop happens in the same cycle.
- FIFO entry holds {write, addr, wdata}. Order is strictly preserved; no reordering or bypass.
- mem_* outputs are combinational from the FIFO head in RUN. The head issues (and pops) when:
  - write head: FIFO non-empty; issues unconditionally.
  - read head: FIFO non-empty && !rd_pending && (!rsp_valid || rsp_ready).
  - A blocked read head blocks all later entries.
- When no entry issues: mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0.
- rd_pending is set on the read issue edge and cleared on the next edge. On that edge, rsp_rdata<=mem_rdata and rsp_valid<=1.
- rsp_valid clears on a handshake, unless a new capture happens on the same edge. At most one read is outstanding.
- Read after write to the same address returns the new data. Write after read returns the old data, because issue is in order.
- Reset (asynchronous, any time):
  - FIFO count=0, rd_pending=0, rsp_valid=0, rsp_rdata=0, sweep counter=0, state re-enters INIT or RUN.
  - Queued and in-flight requests are dropped.
  - While reset is high: req_ready=0, mem_wr_en=0, mem_rd_en=0, busy=0.

## Timing
- Write: accepted in cycle A (empty FIFO), issued in cycle A+1.
- Read: accepted in cycle A, mem_rd_en in A+1, mem_rdata in A+2, rsp_valid=1 from A+3.
- Throughput: 1 write/cycle. Reads are at most 1 per 2 cycles, and only while rsp_ready is held high.
- Init sweep: 2**ADDR_WIDTH cycles after reset deassertion. req_ready can first be 1 in cycle 2**ADDR_WIDTH (counting from 0).
- rsp_valid/rsp_rdata stay stable while rsp_valid && !rsp_ready.

## Configuration
- MEM_REQ_CTRL_INIT_SWEEP_EN defined: INIT state and sweep counter are present; busy behaves as above.
- Undefined: no INIT state; RUN directly after reset; busy tied 0; memory contents after reset are whatever the memory holds.

## Test plan
- Macro on, defaults: release reset → cycles 0..3 mem_wr_en=1, mem_addr 0,1,2,3, mem_wdata 0xFF, busy=1 → cycle 4: busy=0, req_ready=1. A subsequent read of addr 1 returns 0xFF.
- Write addr 2 = 0x5A, then read addr 2 back-to-back → mem_wr_en one cycle, then mem_rd_en. rsp_rdata=0x5A, rsp_valid 3 cycles after read acceptance.
- rsp_ready=0, reads of addr 0 and addr 1 → first response held stable. Second read is not issued until the first handshake, then responds in order.
- rsp_ready=0, 6 back-to-back reads → exactly 5 accepted; req_ready=0 with count=4. Releasing rsp_ready drains all 5 responses in order.
- Reset pulse while rsp_valid=1 and 3 entries queued → next edge rsp_valid=0, FIFO empty, no stale mem_rd_en. Sweep restarts at addr 0 (macro on).
- Macro off: release reset → req_ready=1 and busy=0 in cycle 0; a write 0x33 then read at addr 3 returns 0x33.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Request front-end for a single-port synchronous memory: in-order request FIFO,
// one outstanding read, backpressured response register. Define MEM_REQ_CTRL_INIT_SWEEP_EN
// to add a post-reset sweep that writes INIT_VALUE to every memory location.
module mem_req_ctrl #(
    parameter int                    ADDR_WIDTH = 2,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic in_init;
    logic in_run;

`ifdef MEM_REQ_CTRL_INIT_SWEEP_EN
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            sweep_addr <= '0;
        end else if (state == ST_INIT) begin
            sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
            if (&sweep_addr) begin
                state <= ST_RUN;
            end
        end
    end

    // Reset gates the decodes so nothing is driven while reset is held.
    assign in_init = (state == ST_INIT) && !reset;
    assign in_run  = (state == ST_RUN) && !reset;
`else
    logic unused_init_value;

    assign unused_init_value = ^INIT_VALUE;
    assign in_init           = 1'b0;
    assign in_run            = !reset;
`endif

    assign busy = in_init;

    // Request FIFO
    logic [FIFO_DEPTH-1:0] fifo_write;
    logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  read_ok;
    logic                  rd_issue;
    logic                  rd_pending;

    assign head_write = fifo_write[rd_ptr];
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_wdata = fifo_wdata[rd_ptr];
    assign fifo_empty = (count == '0);

    // Readiness depends only on the registered count, so a full FIFO refuses
    // a push even when the head pops in the same cycle.
    assign req_ready = in_run && (count < CNT_W'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;

    assign read_ok  = !rd_pending && (!rsp_valid || rsp_ready);
    assign pop      = in_run && !fifo_empty && (head_write || read_ok);
    assign rd_issue = pop && !head_write;

    // NOTE: the FIFO storage has no reset; entries are only ever read below
    // the count, which is reset, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write[wr_ptr] <= req_write;
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_wdata[wr_ptr] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef MEM_REQ_CTRL_INIT_SWEEP_EN
        if (in_init) begin
            mem_wr_en = 1'b1;
            mem_addr  = sweep_addr;
            mem_wdata = INIT_VALUE;
        end
`endif
        if (pop) begin
            mem_wr_en = head_write;
            mem_rd_en = !head_write;
            mem_addr  = head_addr;
            mem_wdata = head_write ? head_wdata : '0;
        end
    end

    // Read data arrives the cycle after issue; capture it into the response
    // register, which holds until the host takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rd_pending <= rd_issue;
            if (rd_pending) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= mem_rdata;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: behavioural memory, shadow-model scoreboard
// of read responses, and cycle-exact checks of sweep, issue timing and reset.
module tb_mem_req_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic [1:0] mem_addr;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;

    logic [7:0] mem [4] = '{default: 8'h00};
    logic [7:0] shadow [4] = '{default: 8'h00};
    logic [7:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_rsp    = 0;
    int n_rd     = 0;
    int mark;

    mem_req_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory with one cycle of read latency
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observes handshakes just before the edge they complete on.
    task automatic monitor();
        logic [7:0] exp;
        if (reset) begin
            exp_q.delete();
`ifdef MEM_REQ_CTRL_INIT_SWEEP_EN
            for (int i = 0; i < 4; i++) shadow[i] = 8'hFF;
`endif
        end else begin
            if (mem_rd_en) n_rd++;
            if (req_valid && req_ready) begin
                n_acc++;
                if (req_write) shadow[req_addr] = req_wdata;
                else exp_q.push_back(shadow[req_addr]);
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_rdata), 32'hDEAD);
                end else begin
                    exp = exp_q.pop_front();
                    check("rsp_data", 32'(rsp_rdata), 32'(exp));
                end
            end
        end
    endtask

    // Cycle step: enter anywhere in the first half, leave at posedge+1.
    task automatic tick();
        @(negedge clk);
        #3;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [1:0] a, input logic [7:0] d);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            #2;
            if (req_ready) done = 1'b1;
            tick();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || rsp_valid); i++) tick();
        #2;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
    endtask

    task automatic wait_rsp_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            #2;
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        if (!seen) check("rsp_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        rsp_ready = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // Outputs while reset is held
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        tick();
        tick();
        reset = 1'b0;

`ifdef MEM_REQ_CTRL_INIT_SWEEP_EN
        for (int i = 0; i < 4; i++) begin
            #2;
            check("sweep_wr_en", 32'(mem_wr_en), 32'd1);
            check("sweep_addr", 32'(mem_addr), 32'(i));
            check("sweep_wdata", 32'(mem_wdata), 32'hFF);
            check("sweep_busy", 32'(busy), 32'd1);
            check("sweep_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        #2;
        check("run_busy", 32'(busy), 32'd0);
        check("run_req_ready", 32'(req_ready), 32'd1);
        send(1'b0, 2'd1, 8'h00);
        idle();
        drain();
`else
        #2;
        check("run_busy", 32'(busy), 32'd0);
        check("run_req_ready", 32'(req_ready), 32'd1);
        send(1'b1, 2'd3, 8'h33);
        send(1'b0, 2'd3, 8'h00);
        idle();
        drain();
`endif
        check("first_rsp_count", 32'(n_rsp), 32'd1);

        // Write then read of the same address, cycle by cycle
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'h5A;
        #2;
        check("wr_accept_ready", 32'(req_ready), 32'd1);
        check("wr_not_yet_issued", 32'(mem_wr_en), 32'd0);
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd2; req_wdata = 8'h00;
        #2;
        check("wr_issue_en", 32'(mem_wr_en), 32'd1);
        check("wr_issue_addr", 32'(mem_addr), 32'd2);
        check("wr_issue_data", 32'(mem_wdata), 32'h5A);
        check("wr_issue_no_rd", 32'(mem_rd_en), 32'd0);
        tick();
        idle();
        #2;
        check("rd_issue_en", 32'(mem_rd_en), 32'd1);
        check("rd_issue_addr", 32'(mem_addr), 32'd2);
        check("rd_issue_no_wr", 32'(mem_wr_en), 32'd0);
        tick();
        #2;
        check("rd_rsp_not_early", 32'(rsp_valid), 32'd0);
        tick();
        #2;
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_data", 32'(rsp_rdata), 32'h5A);
        tick();
        drain();

        // Held response blocks the next read
        send(1'b1, 2'd0, 8'h11);
        send(1'b1, 2'd1, 8'h22);
        idle();
        rsp_ready = 1'b0;
        send(1'b0, 2'd0, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        idle();
        wait_rsp_valid();
        for (int i = 0; i < 4; i++) begin
            #2;
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_data", 32'(rsp_rdata), 32'h11);
            check("hold_no_rd_issue", 32'(mem_rd_en), 32'd0);
            tick();
        end
        mark = n_rsp;
        drain();
        check("hold_rsp_count", 32'(n_rsp - mark), 32'd2);

        // Six reads against a stalled response: five fit
        rsp_ready = 1'b0;
        mark = n_acc;
        send(1'b0, 2'd0, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b0, 2'd2, 8'h00);
        send(1'b0, 2'd3, 8'h00);
        send(1'b0, 2'd0, 8'h00);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1;
        for (int i = 0; i < 8; i++) tick();
        #2;
        check("full_req_ready", 32'(req_ready), 32'd0);
        check("full_accepted", 32'(n_acc - mark), 32'd5);
        tick();
        idle();
        mark = n_rsp;
        drain();
        check("full_rsp_count", 32'(n_rsp - mark), 32'd5);

        // Reset with a held response and three queued reads
        rsp_ready = 1'b0;
        send(1'b0, 2'd3, 8'h00);
        send(1'b0, 2'd2, 8'h00);
        send(1'b0, 2'd1, 8'h00);
        send(1'b0, 2'd0, 8'h00);
        idle();
        wait_rsp_valid();
        tick();
        reset = 1'b1;
        #2;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        mark = n_rd;
`ifdef MEM_REQ_CTRL_INIT_SWEEP_EN
        #2;
        check("resweep_wr_en", 32'(mem_wr_en), 32'd1);
        check("resweep_addr", 32'(mem_addr), 32'd0);
        check("resweep_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) tick();
`endif
        for (int i = 0; i < 6; i++) tick();
        #2;
        check("post_rst_no_rd", 32'(n_rd - mark), 32'd0);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        tick();

        // Memory contents after reset come from the sweep or survive it
        mark = n_rsp;
        send(1'b0, 2'd2, 8'h00);
        idle();
        drain();
        check("post_rst_rsp_count", 32'(n_rsp - mark), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
